// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with internal pixel clock-enable
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_DIV  = 4,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Decode boundaries held as 32-bit unsigned so compares against the
  // zero-extended counters stay width-clean even if H_TOTAL itself overflows CW.
  localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  // Reject parameter sets the counters cannot represent.
  generate
    if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
    if (CW < 31 && (H_TOTAL - 1) >= (1 << CW)) begin : g_bad_hcw
      $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
    end
    if (CW < 31 && (V_TOTAL - 1) >= (1 << CW)) begin : g_bad_vcw
      $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
    end
  endgenerate

  logic [DW-1:0] div;
  logic          adv;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          hs_on;
  logic          vs_on;
  logic          act_next;

  assign adv = en && (div == DIV_LAST);

  // Next raster position; vcount only moves on an hcount wrap.
  always_comb begin
    h_wrap = (hcount == CW'(H_TOTAL - 1));
    v_wrap = (vcount == CW'(V_TOTAL - 1));
    h_next = h_wrap ? '0 : hcount + 1'b1;
    v_next = vcount;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : vcount + 1'b1;
    end
  end

  // Sync and visibility decoded from the next position so they register alongside it.
  always_comb begin
    hs_on    = (32'(h_next) >= HS_START) && (32'(h_next) < HS_END);
    vs_on    = (32'(v_next) >= VS_START) && (32'(v_next) < VS_END);
    act_next = (32'(h_next) < H_VIS) && (32'(v_next) < V_VIS);
  end

  // Pixel divider: free-runs while enabled, holds its phase while disabled.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Raster counters and registered outputs; state moves only on an advance.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hcount      <= CW'(H_TOTAL - 1);
      vcount      <= CW'(V_TOTAL - 1);
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      active      <= 1'b0;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_ce      <= adv;
      line_start  <= adv && h_wrap;
      frame_start <= adv && h_wrap && v_wrap;
      if (adv) begin
        hcount <= h_next;
        vcount <= v_next;
        hsync  <= hs_on ? HS_ON : ~HS_ON;
        vsync  <= vs_on ? VS_ON : ~VS_ON;
        active <= act_next;
      end
    end
  end

endmodule
